mem_stage_pipe: RTL

- Parametrised, multi-cycle successor of the single-cycle memory stage; sits between EX/MEM and MEM/WB in the 5-stage pipeline.
- Owns a word-organised data RAM with byte, half, word and double accesses, load sign/zero extension and a configurable access latency.
- Raises `stall` to freeze upstream stages while an access is in flight.
- Registers its result into MEM/WB-side outputs.

---
 rtl/mem_stage_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_pipe.sv
// Multi-cycle MEM stage: byte/half/word/double loads and stores against a word RAM.
// Optional macro MEM_STAGE_MISALIGN_CHK_EN flags and suppresses misaligned accesses.
module mem_stage_pipe #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic                  reg_write_in,
   output logic                  stall,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic                  reg_write_out,
   output logic                  misalign
);

   localparam int unsigned OFF   = $clog2(DATA_WIDTH / 8);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [1:0]  MAX_SIZE = (DATA_WIDTH == 64) ? 2'd3 : 2'd2;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [DATA_WIDTH-1:0]   ram [DEPTH];

   logic                    lat_wr;
   logic                    lat_uns;
   logic                    lat_mis;
   logic [1:0]              lat_size;
   logic [OFF-1:0]          lat_off;
   logic [IDX_W-1:0]        lat_idx;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic [REG_ADDR_W-1:0]   lat_rd;
   logic                    lat_rw;

   // Decode of the presented instruction, latched on acceptance
   logic [1:0]              size_c;
   logic [OFF-1:0]          size_mask_c;
   logic [OFF-1:0]          off_c;
   logic [IDX_W-1:0]        idx_c;
   logic                    mis_c;
   logic                    accept_mem_c;

   always_comb begin
      size_c       = (funct3[1:0] > MAX_SIZE) ? MAX_SIZE : funct3[1:0];
      size_mask_c  = OFF'((4'd1 << size_c) - 4'd1);
      off_c        = address[OFF-1:0] & ~size_mask_c;
      idx_c        = address[OFF+IDX_W-1:OFF];
`ifdef MEM_STAGE_MISALIGN_CHK_EN
      mis_c        = (address[OFF-1:0] & size_mask_c) != '0;
`else
      mis_c        = 1'b0;
`endif
      accept_mem_c = (state == IDLE) && in_valid && (mem_read || mem_write);
   end

   assign stall = accept_mem_c || (state == BUSY);

   // Lane shifting and extension for the in-flight access
   logic [6:0]              nbits_c;
   logic [DATA_WIDTH-1:0]   hi_mask_c;
   logic [DATA_WIDTH-1:0]   byte_mask_c;
   logic [DATA_WIDTH-1:0]   word_c;
   logic [DATA_WIDTH-1:0]   shifted_c;
   logic [DATA_WIDTH-1:0]   merged_c;
   logic [DATA_WIDTH-1:0]   load_c;
   logic                    sign_c;
   logic                    commit_c;

   always_comb begin
      nbits_c     = 7'd8 << lat_size;
      hi_mask_c   = {DATA_WIDTH{1'b1}} << nbits_c;
      byte_mask_c = ~hi_mask_c << {lat_off, 3'b000};
      word_c      = ram[lat_idx];
      merged_c    = (word_c & ~byte_mask_c) | ((lat_wdata << {lat_off, 3'b000}) & byte_mask_c);
      shifted_c   = word_c >> {lat_off, 3'b000};
      case (lat_size)
         2'd0:    sign_c = shifted_c[7];
         2'd1:    sign_c = shifted_c[15];
         2'd2:    sign_c = shifted_c[31];
         default: sign_c = shifted_c[DATA_WIDTH-1];
      endcase
      load_c      = (shifted_c & ~hi_mask_c) | ((sign_c && !lat_uns) ? hi_mask_c : '0);
      commit_c    = (state == BUSY) && (cnt == '0);
   end

   // RAM is not reset; an async reset drops state to IDLE and so suppresses the write
   always_ff @(posedge clock) begin
      if (commit_c && lat_wr && !lat_mis) begin
         ram[lat_idx] <= merged_c;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         cnt           <= '0;
         out_valid     <= 1'b0;
         wb_data       <= '0;
         rd_out        <= '0;
         reg_write_out <= 1'b0;
         misalign      <= 1'b0;
         lat_wr        <= 1'b0;
         lat_uns       <= 1'b0;
         lat_mis       <= 1'b0;
         lat_size      <= '0;
         lat_off       <= '0;
         lat_idx       <= '0;
         lat_wdata     <= '0;
         lat_rd        <= '0;
         lat_rw        <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (mem_read || mem_write) begin
                     state     <= BUSY;
                     cnt       <= CNT_W'(LATENCY - 1);
                     lat_wr    <= mem_write;
                     lat_uns   <= funct3[2];
                     lat_mis   <= mis_c;
                     lat_size  <= size_c;
                     lat_off   <= off_c;
                     lat_idx   <= idx_c;
                     lat_wdata <= write_data;
                     lat_rd    <= rd_in;
                     lat_rw    <= reg_write_in;
                  end else begin
                     out_valid     <= 1'b1;
                     wb_data       <= address[DATA_WIDTH-1:0];
                     rd_out        <= rd_in;
                     reg_write_out <= reg_write_in;
                     misalign      <= 1'b0;
                  end
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state     <= IDLE;
                  out_valid <= 1'b1;
                  rd_out    <= lat_rd;
                  misalign  <= lat_mis;
                  if (lat_wr || lat_mis) begin
                     wb_data       <= '0;
                     reg_write_out <= 1'b0;
                  end else begin
                     wb_data       <= load_c;
                     reg_write_out <= lat_rw;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
